iso_rx_sequencer: RTL and testbench

- Controller for the ISO7816 character receiver core: latches its bit timing configuration, acknowledges its flags, buffers received bytes in a FIFO, and counts parity and frame errors.
- Implements the character waiting time (CWT) timeout in ETUs and recovers the core from overrun by pulsing its reset.
- Sits between the receiver core and the host register and bus interface.

---
 rtl/iso_rx_sequencer_pkg.sv | 19 +
 rtl/iso_rx_sequencer_if.sv | 29 ++
 rtl/iso_rx_sequencer_fifo.sv | 48 ++++
 rtl/iso_rx_sequencer.sv | 135 +++++++++++++
 tb/tb_iso_rx_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iso_rx_sequencer_pkg.sv
// rtl/iso_rx_sequencer_pkg.sv - shared state encodings and constants for the ISO7816 receive sequencer
package iso_rx_sequencer_pkg;

  typedef enum logic [1:0] {
    DISABLED  = 2'b00,
    IDLE_WAIT = 2'b01,
    RECEIVING = 2'b11,
    RECOVER   = 2'b10
  } rxState_t;

  localparam int DEFAULT_CLOCK_PER_BIT_WIDTH = 13;
  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

  // Saturating increment for the error counter.
  function automatic logic [7:0] errCountInc(input logic [7:0] value);
    return (value == ERR_COUNT_MAX) ? ERR_COUNT_MAX : value + 8'd1;
  endfunction

endpackage

// File: rtl/iso_rx_sequencer_if.sv
// rtl/iso_rx_sequencer_if.sv - signals between the sequencer and the ISO7816 receiver core
interface iso_rx_sequencer_if
  import iso_rx_sequencer_pkg::*;
#(
  parameter int CLOCK_PER_BIT_WIDTH = DEFAULT_CLOCK_PER_BIT_WIDTH
);
  logic [7:0]                     rxData;
  logic                           rxDataReady;
  logic                           rxFrameError;
  logic                           rxOverrun;
  logic                           rxRun;
  logic                           rxStartBit;
  logic                           rxAck;
  logic [CLOCK_PER_BIT_WIDTH-1:0] rxClocksPerBit;
  logic                           rxStopBit2;
  logic                           rxCoreResetN;

  // Sequencer side.
  modport master (
    input  rxData, rxDataReady, rxFrameError, rxOverrun, rxRun, rxStartBit,
    output rxAck, rxClocksPerBit, rxStopBit2, rxCoreResetN
  );

  // Receiver core side.
  modport slave (
    output rxData, rxDataReady, rxFrameError, rxOverrun, rxRun, rxStartBit,
    input  rxAck, rxClocksPerBit, rxStopBit2, rxCoreResetN
  );
endinterface

// File: rtl/iso_rx_sequencer_fifo.sv
// rtl/iso_rx_sequencer_fifo.sv - synchronous byte FIFO holding received characters
module iso_rx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wrEn,
  input  logic [7:0]  wrData,
  input  logic        rdEn,
  output logic [7:0]  rdData,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic          doWrite, doRead;

  // A full FIFO still accepts a write when a read frees the head slot in the same cycle.
  assign doRead  = rdEn && !empty;
  assign doWrite = wrEn && (!full || rdEn);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdData  = empty ? 8'h00 : mem[rdPtr];

  // Storage array; no reset needed since entries are only visible once written.
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= wrData;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + AW'(1);
      if (doRead)  rdPtr <= rdPtr + AW'(1);
      case ({doWrite, doRead})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/iso_rx_sequencer.sv
// rtl/iso_rx_sequencer.sv - controller for the ISO7816 character receiver core
module iso_rx_sequencer
  import iso_rx_sequencer_pkg::*;
#(
  parameter int CLOCK_PER_BIT_WIDTH = DEFAULT_CLOCK_PER_BIT_WIDTH,
  parameter int FIFO_DEPTH          = 8,
  parameter int WAIT_WIDTH          = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] cfgClocksPerBit,
  input  logic                           cfgStopBit2,
  input  logic [WAIT_WIDTH-1:0]          cfgWaitEtu,
  input  logic                           clearErrors,
  input  logic                           fifoRead,
  output logic [7:0]                     fifoData,
  output logic                           fifoEmpty,
  output logic [$clog2(FIFO_DEPTH):0]    fifoCount,
  output logic                           fifoOverflow,
  output logic                           overrunSticky,
  output logic                           timeoutFlag,
  output logic [7:0]                     errCount,
  output logic                           busy,
  iso_rx_sequencer_if.master             core
);
  rxState_t                       state, nextState;
  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBitQ, clkCnt;
  logic                           stopBit2Q;
  logic [WAIT_WIDTH-1:0]          waitEtuQ, etuCnt;
  logic                           recoverDone, rxAckQ, coreResetNQ;
  logic                           active, flagEvent, frameErrEvent, fifoWrite, fifoFull;
  logic                           overflowEvent, overrunEvent, etuWrap, cwtFrozen, timeoutEvent;

  assign active        = (state == IDLE_WAIT) || (state == RECEIVING);
  // The registered ack blocks a second acknowledge of the same flag.
  assign flagEvent     = active && (core.rxDataReady || core.rxFrameError) && !rxAckQ;
  assign frameErrEvent = flagEvent && core.rxFrameError;
  assign fifoWrite     = flagEvent && core.rxDataReady && !core.rxFrameError;
  assign overflowEvent = fifoWrite && fifoFull && !fifoRead;
  assign overrunEvent  = active && core.rxOverrun;
  assign etuWrap       = (clkCnt == clocksPerBitQ);
  // Once the CWT is reached the counters stay put, so a cleared timeout cannot re-fire.
  assign cwtFrozen     = (waitEtuQ != '0) && (etuCnt == waitEtuQ);
  assign timeoutEvent  = (state == IDLE_WAIT) && (nextState == IDLE_WAIT) && !cwtFrozen && etuWrap
                         && (waitEtuQ != '0) && ((etuCnt + WAIT_WIDTH'(1)) == waitEtuQ);

  assign busy                = core.rxStartBit || core.rxRun;
  assign core.rxAck          = rxAckQ;
  assign core.rxClocksPerBit = clocksPerBitQ;
  assign core.rxStopBit2     = stopBit2Q;
  assign core.rxCoreResetN   = coreResetNQ;

  iso_rx_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .reset(reset), .wrEn(fifoWrite), .wrData(core.rxData), .rdEn(fifoRead),
    .rdData(fifoData), .full(fifoFull), .empty(fifoEmpty), .count(fifoCount)
  );

  // Next-state selection; dropping enable wins over everything else.
  always_comb begin
    nextState = state;
    case (state)
      DISABLED:  if (enable) nextState = IDLE_WAIT;
      IDLE_WAIT: if (overrunEvent) nextState = RECOVER;
                 else if (core.rxStartBit) nextState = RECEIVING;
      RECEIVING: if (overrunEvent) nextState = RECOVER;
                 else if (!core.rxStartBit && !core.rxRun) nextState = IDLE_WAIT;
      RECOVER:   if (recoverDone) nextState = IDLE_WAIT;
      default:   nextState = DISABLED;
    endcase
    if (!enable) nextState = DISABLED;
  end

  // State register, configuration latch, core handshake and core reset pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= DISABLED;
      clocksPerBitQ <= '0;
      stopBit2Q     <= 1'b0;
      waitEtuQ      <= '0;
      recoverDone   <= 1'b0;
      rxAckQ        <= 1'b0;
      coreResetNQ   <= 1'b1;
    end else begin
      state <= nextState;
      if (state == DISABLED && enable) begin
        clocksPerBitQ <= cfgClocksPerBit;
        stopBit2Q     <= cfgStopBit2;
        waitEtuQ      <= cfgWaitEtu;
      end
      recoverDone <= (state == RECOVER);
      rxAckQ      <= flagEvent;
      coreResetNQ <= (nextState != RECOVER);
    end
  end

  // CWT counters: run only while idling, cleared on entry to IDLE_WAIT or RECEIVING, else held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkCnt <= '0;
      etuCnt <= '0;
    end else if (state == IDLE_WAIT && nextState == IDLE_WAIT) begin
      if (!cwtFrozen) begin
        if (etuWrap) begin
          clkCnt <= '0;
          etuCnt <= etuCnt + WAIT_WIDTH'(1);
        end else begin
          clkCnt <= clkCnt + CLOCK_PER_BIT_WIDTH'(1);
        end
      end
    end else if (nextState == IDLE_WAIT || nextState == RECEIVING) begin
      clkCnt <= '0;
      etuCnt <= '0;
    end
  end

  // Sticky flags and error counter; a same-cycle event beats clearErrors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifoOverflow  <= 1'b0;
      overrunSticky <= 1'b0;
      timeoutFlag   <= 1'b0;
      errCount      <= 8'h00;
    end else begin
      if (overflowEvent)    fifoOverflow <= 1'b1;
      else if (clearErrors) fifoOverflow <= 1'b0;
      if (overrunEvent)     overrunSticky <= 1'b1;
      else if (clearErrors) overrunSticky <= 1'b0;
      if (timeoutEvent)     timeoutFlag <= 1'b1;
      else if (clearErrors) timeoutFlag <= 1'b0;
      if (frameErrEvent)    errCount <= clearErrors ? 8'd1 : errCountInc(errCount);
      else if (clearErrors) errCount <= 8'h00;
    end
  end
endmodule

// File: tb/tb_iso_rx_sequencer.sv
// tb/tb_iso_rx_sequencer.sv - directed self-checking bench for iso_rx_sequencer
module tb_iso_rx_sequencer;
  logic        clk;
  logic        reset;
  logic        enable;
  logic [12:0] cfgClocksPerBit;
  logic        cfgStopBit2;
  logic [15:0] cfgWaitEtu;
  logic        clearErrors;
  logic        fifoRead;
  logic [7:0]  fifoData;
  logic        fifoEmpty;
  logic [3:0]  fifoCount;
  logic        fifoOverflow;
  logic        overrunSticky;
  logic        timeoutFlag;
  logic [7:0]  errCount;
  logic        busy;
  int          checks;
  int          failures;

  iso_rx_sequencer_if #(.CLOCK_PER_BIT_WIDTH(13)) coreIf ();

  iso_rx_sequencer #(.CLOCK_PER_BIT_WIDTH(13), .FIFO_DEPTH(8), .WAIT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfgClocksPerBit(cfgClocksPerBit),
    .cfgStopBit2(cfgStopBit2), .cfgWaitEtu(cfgWaitEtu), .clearErrors(clearErrors),
    .fifoRead(fifoRead), .fifoData(fifoData), .fifoEmpty(fifoEmpty), .fifoCount(fifoCount),
    .fifoOverflow(fifoOverflow), .overrunSticky(overrunSticky), .timeoutFlag(timeoutFlag),
    .errCount(errCount), .busy(busy), .core(coreIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Core raises data-ready, sees exactly one ack, then drops its flag.
  task automatic sendByte(input logic [7:0] b, input string tag);
    coreIf.rxData = b;
    coreIf.rxDataReady = 1'b1;
    tick();
    checkValue({tag, "_ack"}, coreIf.rxAck, 1);
    coreIf.rxDataReady = 1'b0;
    tick();
    checkValue({tag, "_ackDrop"}, coreIf.rxAck, 0);
  endtask

  task automatic readByte();
    fifoRead = 1'b1;
    tick();
    fifoRead = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    enable = 1'b0;
    cfgClocksPerBit = 13'd372;
    cfgStopBit2 = 1'b0;
    cfgWaitEtu = 16'd0;
    clearErrors = 1'b0;
    fifoRead = 1'b0;
    coreIf.rxData = 8'h00;
    coreIf.rxDataReady = 1'b0;
    coreIf.rxFrameError = 1'b0;
    coreIf.rxOverrun = 1'b0;
    coreIf.rxRun = 1'b0;
    coreIf.rxStartBit = 1'b0;
    tickN(3);
    checkValue("rst_fifoEmpty", fifoEmpty, 1);
    checkValue("rst_fifoCount", fifoCount, 0);
    checkValue("rst_fifoData", fifoData, 0);
    checkValue("rst_coreResetN", coreIf.rxCoreResetN, 1);
    checkValue("rst_ack", coreIf.rxAck, 0);
    checkValue("rst_cpb", coreIf.rxClocksPerBit, 0);
    checkValue("rst_errCount", errCount, 0);
    checkValue("rst_timeout", timeoutFlag, 0);

    // Two bytes received and read back in order.
    reset = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    checkValue("en_cpb", coreIf.rxClocksPerBit, 372);
    checkValue("en_stop2", coreIf.rxStopBit2, 0);
    sendByte(8'h3B, "b0");
    sendByte(8'h96, "b1");
    checkValue("two_count", fifoCount, 2);
    checkValue("two_head", fifoData, 8'h3B);
    readByte();
    checkValue("rd1_data", fifoData, 8'h96);
    readByte();
    checkValue("rd2_empty", fifoEmpty, 1);
    coreIf.rxStartBit = 1'b1;
    #1;
    checkValue("busy_start", busy, 1);
    coreIf.rxStartBit = 1'b0;
    #1;
    checkValue("busy_idle", busy, 0);

    // Frame errors: counted, acknowledged, never stored; saturate at 255.
    coreIf.rxFrameError = 1'b1;
    tick();
    checkValue("fe_ack", coreIf.rxAck, 1);
    checkValue("fe_count1", errCount, 1);
    checkValue("fe_fifo", fifoCount, 0);
    coreIf.rxFrameError = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      coreIf.rxFrameError = 1'b1;
      tick();
      coreIf.rxFrameError = 1'b0;
      tick();
    end
    checkValue("fe_sat", errCount, 255);
    clearErrors = 1'b1;
    coreIf.rxFrameError = 1'b1;
    tick();
    checkValue("fe_clrWins", errCount, 1);
    coreIf.rxFrameError = 1'b0;
    tick();
    tick();
    clearErrors = 1'b0;
    checkValue("fe_cleared", errCount, 0);

    // Overflow: nine bytes into eight slots, then a write with a same-cycle read.
    for (int i = 0; i < 9; i++) sendByte(8'h10 + 8'(i), "ovf");
    checkValue("ovf_count", fifoCount, 8);
    checkValue("ovf_flag", fifoOverflow, 1);
    checkValue("ovf_head", fifoData, 8'h10);
    clearErrors = 1'b1;
    tick();
    clearErrors = 1'b0;
    checkValue("ovf_cleared", fifoOverflow, 0);
    coreIf.rxData = 8'h19;
    coreIf.rxDataReady = 1'b1;
    fifoRead = 1'b1;
    tick();
    coreIf.rxDataReady = 1'b0;
    fifoRead = 1'b0;
    checkValue("rw_count", fifoCount, 8);
    checkValue("rw_noOvf", fifoOverflow, 0);
    checkValue("rw_head", fifoData, 8'h11);
    tick();
    for (int i = 0; i < 7; i++) readByte();
    checkValue("rw_last", fifoData, 8'h19);
    readByte();
    checkValue("drain_empty", fifoEmpty, 1);
    readByte();
    checkValue("rdEmpty_count", fifoCount, 0);

    // Character waiting time: 3 ETUs of 11 clocks.
    enable = 1'b0;
    tick();
    cfgWaitEtu = 16'd3;
    cfgClocksPerBit = 13'd10;
    enable = 1'b1;
    tick();
    checkValue("cwt_cpb", coreIf.rxClocksPerBit, 10);
    tickN(32);
    checkValue("cwt_early", timeoutFlag, 0);
    tick();
    checkValue("cwt_fire", timeoutFlag, 1);
    clearErrors = 1'b1;
    tick();
    clearErrors = 1'b0;
    checkValue("cwt_cleared", timeoutFlag, 0);
    tickN(50);
    checkValue("cwt_noRefire", timeoutFlag, 0);
    coreIf.rxStartBit = 1'b1;
    tick();
    coreIf.rxStartBit = 1'b0;
    coreIf.rxRun = 1'b1;
    tickN(40);
    checkValue("cwt_recv", timeoutFlag, 0);
    coreIf.rxRun = 1'b0;
    tick();
    tickN(32);
    checkValue("cwt2_early", timeoutFlag, 0);
    tick();
    checkValue("cwt2_fire", timeoutFlag, 1);

    // Overrun recovery: core reset low for two cycles, flags ignored meanwhile.
    coreIf.rxOverrun = 1'b1;
    tick();
    coreIf.rxOverrun = 1'b0;
    checkValue("ovr_sticky", overrunSticky, 1);
    checkValue("ovr_rstA", coreIf.rxCoreResetN, 0);
    coreIf.rxData = 8'hA5;
    coreIf.rxDataReady = 1'b1;
    tick();
    checkValue("ovr_rstB", coreIf.rxCoreResetN, 0);
    checkValue("ovr_ackB", coreIf.rxAck, 0);
    tick();
    checkValue("ovr_rstC", coreIf.rxCoreResetN, 1);
    checkValue("ovr_ackC", coreIf.rxAck, 0);
    tick();
    checkValue("ovr_ackD", coreIf.rxAck, 1);
    checkValue("ovr_countD", fifoCount, 1);
    checkValue("ovr_dataD", fifoData, 8'hA5);
    coreIf.rxDataReady = 1'b0;
    tick();
    readByte();

    // Configuration only latches from DISABLED.
    cfgClocksPerBit = 13'd200;
    cfgStopBit2 = 1'b1;
    tick();
    checkValue("cfg_hold_cpb", coreIf.rxClocksPerBit, 10);
    checkValue("cfg_hold_stop2", coreIf.rxStopBit2, 0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    checkValue("cfg_new_cpb", coreIf.rxClocksPerBit, 200);
    checkValue("cfg_new_stop2", coreIf.rxStopBit2, 1);

    // Asynchronous reset in the middle of a character.
    sendByte(8'h5A, "pre");
    coreIf.rxStartBit = 1'b1;
    coreIf.rxRun = 1'b1;
    tick();
    checkValue("mid_busy", busy, 1);
    #3;
    coreIf.rxStartBit = 1'b0;
    coreIf.rxRun = 1'b0;
    reset = 1'b0;
    #1;
    checkValue("ar_fifoEmpty", fifoEmpty, 1);
    checkValue("ar_fifoCount", fifoCount, 0);
    checkValue("ar_cpb", coreIf.rxClocksPerBit, 0);
    checkValue("ar_stop2", coreIf.rxStopBit2, 0);
    checkValue("ar_overrun", overrunSticky, 0);
    checkValue("ar_timeout", timeoutFlag, 0);
    checkValue("ar_coreResetN", coreIf.rxCoreResetN, 1);
    checkValue("ar_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
